// File: rtl/spi_voltage_receiver.sv
// SPI mode-0 slave receiver: oversamples SCLK/MOSI/SS in the clk domain and hands out one word
// per SS frame on a valid/ready port. Optional SCLK-stall abort is enabled by RX_TIMEOUT_EN.
module spi_voltage_receiver #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spi_clk,
    input  logic                         spi_mosi,
    input  logic                         spi_ss,
    output logic [DATA_W-1:0]            rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic                         frame_err,
    output logic                         overrun,
    output logic                         busy,
    output logic [$clog2(DATA_W+1)-1:0]  debug_bit_count
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DATA_W);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("spi_voltage_receiver: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES > 0");
    end

    typedef enum logic [1:0] {StIdle, StShift, StCommit, StWaitSs} state_e;

    logic [SYNC_STAGES-1:0] sclk_chain_q, mosi_chain_q, ss_chain_q, fill_q;
    logic                   sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_prev_q, ss_prev_q, mosi_q;
    logic                   sclk_rise_q, ss_fall_q, ss_rise_q, armed_q;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d, rx_data_q, rx_data_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   too_many_q, too_many_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d, overrun_q, overrun_d;

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
    logic [TmrW-1:0] timer_q, timer_d;
`endif

    assign sclk_sync = sclk_chain_q[SYNC_STAGES-1];
    assign mosi_sync = mosi_chain_q[SYNC_STAGES-1];
    assign ss_sync   = ss_chain_q[SYNC_STAGES-1];

    // fill_q marks when the chains hold real pin samples rather than their reset presets, so a
    // preset SS=1 cannot arm the receiver while the pin is actually low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_chain_q <= '0;
            mosi_chain_q <= '0;
            ss_chain_q   <= '1;
            fill_q       <= '0;
            sclk_prev_q  <= 1'b0;
            ss_prev_q    <= 1'b1;
            mosi_q       <= 1'b0;
            sclk_rise_q  <= 1'b0;
            ss_fall_q    <= 1'b0;
            ss_rise_q    <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            sclk_chain_q <= {sclk_chain_q[SYNC_STAGES-2:0], spi_clk};
            mosi_chain_q <= {mosi_chain_q[SYNC_STAGES-2:0], spi_mosi};
            ss_chain_q   <= {ss_chain_q[SYNC_STAGES-2:0], spi_ss};
            fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q  <= sclk_sync;
            ss_prev_q    <= ss_sync;
            mosi_q       <= mosi_sync;
            sclk_rise_q  <= sclk_sync & ~sclk_prev_q;
            ss_fall_q    <= ss_prev_q & ~ss_sync;
            ss_rise_q    <= ss_sync & ~ss_prev_q;
            armed_q      <= armed_q | (ss_sync & fill_q[SYNC_STAGES-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            count_q     <= '0;
            too_many_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            too_many_q  <= too_many_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef RX_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        too_many_d  = too_many_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef RX_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (ss_fall_q && armed_q) begin
                    state_d    = StShift;
                    shift_d    = '0;
                    count_d    = '0;
                    too_many_d = 1'b0;
`ifdef RX_TIMEOUT_EN
                    timer_d    = '0;
`endif
                end
            end
            StShift: begin
                // SS release takes priority over a coincident SCLK edge.
                if (ss_rise_q) begin
                    if (count_q == FullCnt && !too_many_q) begin
                        state_d = StCommit;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end
                end else if (sclk_rise_q) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_q};
                    if (count_q == FullCnt) begin
                        too_many_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
`ifdef RX_TIMEOUT_EN
                    timer_d = '0;
                end else if (timer_q == TmrLast) begin
                    frame_err_d = 1'b1;
                    state_d     = StWaitSs;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (rx_valid_q && !rx_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                end
            end
`ifdef RX_TIMEOUT_EN
            StWaitSs: begin
                if (ss_sync) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign frame_err       = frame_err_q;
    assign overrun         = overrun_q;
    assign busy            = (state_q != StIdle);
    assign debug_bit_count = (state_q == StShift) ? count_q : '0;

endmodule

// File: tb/tb_spi_voltage_receiver.sv
// Directed bench for spi_voltage_receiver: framing, overrun, reset and SS-arming cases, with
// pulse counters sampled on the falling clk edge.
module tb_spi_voltage_receiver;

    localparam int unsigned DataW = 8;
    localparam int unsigned CntW  = $clog2(DataW + 1);

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic             spi_clk  = 1'b0;
    logic             spi_mosi = 1'b0;
    logic             spi_ss   = 1'b1;
    logic             rx_ready = 1'b0;
    logic [DataW-1:0] rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;
    logic [CntW-1:0]  debug_bit_count;

    always #5 clk = ~clk;

    spi_voltage_receiver #(
        .DATA_W         (DataW),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .spi_clk         (spi_clk),
        .spi_mosi        (spi_mosi),
        .spi_ss          (spi_ss),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .frame_err       (frame_err),
        .overrun         (overrun),
        .busy            (busy),
        .debug_bit_count (debug_bit_count)
    );

    int   checks    = 0;
    int   errors    = 0;
    int   fe_cnt    = 0;
    int   ov_cnt    = 0;
    int   vrise_cnt = 0;
    int   both_cnt  = 0;
    logic valid_prev = 1'b0;
    int   fe0, ov0, vr0;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid && !valid_prev) vrise_cnt++;
        valid_prev = rx_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ss_low();
        spi_ss = 1'b0;
        wait_clk(8);
    endtask

    task automatic ss_high();
        spi_ss = 1'b1;
        wait_clk(12);
    endtask

    // MSB first, data set up during SCLK low, 16-clk SCLK period.
    task automatic shift_bits(input logic [15:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            wait_clk(8);
            spi_clk = 1'b1;
            wait_clk(8);
            spi_clk = 1'b0;
        end
        wait_clk(4);
    endtask

    task automatic frame(input logic [7:0] val);
        ss_low();
        shift_bits({8'h00, val}, 8);
        ss_high();
    endtask

    task automatic snap();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        vr0 = vrise_cnt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        wait_clk(3);
        check_eq("reset_outputs", {rx_data, rx_valid, frame_err, overrun, busy, debug_bit_count},
                 '0);
        reset = 1'b1;
        wait_clk(5);

        // Single frame with latency check: SS sampled high at edge 1, rx_valid at edge 5.
        rx_ready = 1'b1;
        snap();
        ss_low();
        shift_bits(16'h00A5, 8);
        spi_ss = 1'b1;
        wait_clk(4);
        check_eq("t1_valid_before", rx_valid, 1'b0);
        wait_clk(1);
        check_eq("t1_valid_edge", rx_valid, 1'b1);
        wait_clk(1);
        check_eq("t1_valid_consumed", rx_valid, 1'b0);
        wait_clk(8);
        check_eq("t1_data", rx_data, 8'hA5);
        check_eq("t1_vrise", vrise_cnt - vr0, 1);
        check_eq("t1_ferr", fe_cnt - fe0, 0);
        check_eq("t1_ovr", ov_cnt - ov0, 0);
        check_eq("t1_busy", busy, 1'b0);

        // Overrun: second frame dropped while the first is still held.
        rx_ready = 1'b0;
        snap();
        frame(8'h3C);
        check_eq("t2_valid1", rx_valid, 1'b1);
        check_eq("t2_data1", rx_data, 8'h3C);
        frame(8'hC3);
        check_eq("t2_ovr", ov_cnt - ov0, 1);
        check_eq("t2_data_held", rx_data, 8'h3C);
        check_eq("t2_valid_held", rx_valid, 1'b1);
        check_eq("t2_ferr", fe_cnt - fe0, 0);
        rx_ready = 1'b1;
        check_eq("t2_valid_pre_consume", rx_valid, 1'b1);
        wait_clk(1);
        check_eq("t2_valid_drop", rx_valid, 1'b0);

        // Short and long frames.
        snap();
        ss_low();
        shift_bits(16'h0055, 7);
        ss_high();
        check_eq("t3_short_ferr", fe_cnt - fe0, 1);
        check_eq("t3_short_valid", rx_valid, 1'b0);
        ss_low();
        shift_bits(16'h01A5, 9);
        ss_high();
        check_eq("t3_long_ferr", fe_cnt - fe0, 2);
        check_eq("t3_long_valid", rx_valid, 1'b0);
        check_eq("t3_vrise", vrise_cnt - vr0, 0);
        check_eq("t3_ovr", ov_cnt - ov0, 0);

        // Reset in the middle of a frame.
        snap();
        ss_low();
        shift_bits(16'h0008, 4);
        check_eq("t4_busy_mid", busy, 1'b1);
        check_eq("t4_count_mid", debug_bit_count, 4);
        reset = 1'b0;
        #1;
        check_eq("t4_reset_outputs",
                 {rx_data, rx_valid, frame_err, overrun, busy, debug_bit_count}, '0);
        spi_ss = 1'b1;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(10);
        check_eq("t4_no_ferr", fe_cnt - fe0, 0);
        frame(8'h81);
        check_eq("t4_data", rx_data, 8'h81);
        check_eq("t4_vrise", vrise_cnt - vr0, 1);

        // SS held low across reset release must not start a frame.
        spi_ss = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(10);
        snap();
        shift_bits(16'h00FF, 8);
        check_eq("t5_not_busy", busy, 1'b0);
        ss_high();
        check_eq("t5_vrise", vrise_cnt - vr0, 0);
        check_eq("t5_ferr", fe_cnt - fe0, 0);
        check_eq("t5_data_cleared", rx_data, 8'h00);
        frame(8'h5A);
        check_eq("t5_data", rx_data, 8'h5A);
        check_eq("t5_vrise2", vrise_cnt - vr0, 1);

        // SCLK stall for 100 clk after 3 bits.
        snap();
        ss_low();
        shift_bits(16'h0005, 3);
        wait_clk(100);
`ifdef RX_TIMEOUT_EN
        check_eq("t6_timeout_ferr", fe_cnt - fe0, 1);
        check_eq("t6_busy_wait", busy, 1'b1);
        ss_high();
        check_eq("t6_busy_released", busy, 1'b0);
        frame(8'h0F);
        check_eq("t6_data", rx_data, 8'h0F);
        check_eq("t6_ferr_total", fe_cnt - fe0, 1);
`else
        check_eq("t6_busy_stall", busy, 1'b1);
        check_eq("t6_count_stall", debug_bit_count, 3);
        check_eq("t6_no_ferr_stall", fe_cnt - fe0, 0);
        shift_bits(16'h0014, 5);
        ss_high();
        check_eq("t6_data", rx_data, 8'hB4);
        check_eq("t6_vrise", vrise_cnt - vr0, 1);
        check_eq("t6_ferr", fe_cnt - fe0, 0);
`endif

        check_eq("never_both_pulses", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
